// File: rtl/aes_round_key_server_pkg.sv
// rtl/aes_round_key_server_pkg.sv - shared AES round-key sizes, FSM states and num_rkeys decode
//
// Purpose: constants and types shared by the round-key server and the inverse
// round datapath helpers.
//   AES_RK_BITS    width of one round key
//   AES_MAX_RKEYS  deepest key schedule (AES-256)
//   AES_KEXP_BITS  width of the packed expanded-key bus
//   NRK_AES*       legal num_rkeys encodings
package aes_round_key_server_pkg;

  localparam int AES_RK_BITS   = 128;
  localparam int AES_MAX_RKEYS = 15;
  localparam int AES_KEXP_BITS = AES_RK_BITS * AES_MAX_RKEYS;

  localparam logic [4:0] NRK_AES128 = 5'd11;
  localparam logic [4:0] NRK_AES192 = 5'd13;
  localparam logic [4:0] NRK_AES256 = 5'd15;

  typedef logic [3:0] rk_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } rks_state_e;

  // Anything that is not a 192/256-bit schedule length is served as AES-128.
  function automatic rk_idx_t decode_num_rkeys(input logic [4:0] num);
    case (num)
      NRK_AES192: return rk_idx_t'(13);
      NRK_AES256: return rk_idx_t'(15);
      default:    return rk_idx_t'(11);
    endcase
  endfunction

endpackage

// File: rtl/aes_inv_mix_columns.sv
// rtl/aes_inv_mix_columns.sv - combinational AES InvMixColumns over a 128-bit state
//
// Purpose: applies the GF(2^8) matrix {0e,0b,0d,09} to each of the four state
// columns; no registers, so it can sit in front of any pipeline stage.
// Ports:
//   state_i  in  128  state, byte 0 (row 0 of column 0) in the MSBs
//   state_o  out 128  InvMixColumns(state_i), same byte order
module aes_inv_mix_columns
  import aes_round_key_server_pkg::*;
(
  input  logic [AES_RK_BITS-1:0] state_i,
  output logic [AES_RK_BITS-1:0] state_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Each constant is built from the x2/x4/x8 multiples: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int j = 0; j < 4; j++) begin
      a[j]  = col[31-8*j -: 8];
      x2[j] = xtime(a[j]);
      x4[j] = xtime(x2[j]);
      x8[j] = xtime(x4[j]);
      m9[j] = x8[j] ^ a[j];
      mb[j] = x8[j] ^ x2[j] ^ a[j];
      md[j] = x8[j] ^ x4[j] ^ a[j];
      me[j] = x8[j] ^ x4[j] ^ x2[j];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign state_o[AES_RK_BITS-1-32*c -: 32] = inv_mix_col(state_i[AES_RK_BITS-1-32*c -: 32]);
  end

endmodule

// File: rtl/aes_round_key_server.sv
// rtl/aes_round_key_server.sv - captures an expanded AES key and serves round keys per beat
//
// Purpose: consumer side of the key expander. The expanded key is captured into
// a shadow copy on key_exp_done_i and copied to the active copy when a session
// starts, so a re-key mid-session never disturbs the keys being served.
// Encrypt sessions serve rk0..rkN-1, decrypt sessions rkN-1..rk0; with EQ_INV
// the middle decrypt keys go through InvMixColumns (equivalent inverse cipher).
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   key_exp_i        expanded key, rk i in bits [1919-128*i -: 128] (rk0 in the MSBs)
//   key_exp_done_i   capture strobe for key_exp_i / num_rkeys_i
//   num_rkeys_i      11/13/15 round keys, anything else served as 11
//   start_i          begin a session (IDLE only); decrypt_i picks the order
//   rk_valid_o/rk_ready_i/rk_data_o/rk_index_o/rk_last_o  round-key stream
//   busy_o           session in progress
//   done_o           pulse the cycle after the final beat is accepted
//   no_key_err_o     pulse when a start arrives before any key was captured
module aes_round_key_server
  import aes_round_key_server_pkg::*;
#(
  parameter bit EQ_INV = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AES_KEXP_BITS-1:0] key_exp_i,
  input  logic                     key_exp_done_i,
  input  logic [4:0]               num_rkeys_i,
  input  logic                     start_i,
  input  logic                     decrypt_i,
  output logic                     rk_valid_o,
  input  logic                     rk_ready_i,
  output logic [AES_RK_BITS-1:0]   rk_data_o,
  output logic [3:0]               rk_index_o,
  output logic                     rk_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     no_key_err_o
);

  logic [AES_KEXP_BITS-1:0] shadow_key_q, active_key_q;
  rk_idx_t                  shadow_n_q, active_n_q;
  logic                     key_loaded_q, dec_q;

  rks_state_e               state_q, state_d;
  logic                     rk_valid_q, rk_valid_d;
  logic [AES_RK_BITS-1:0]   rk_data_q, rk_data_d;
  rk_idx_t                  rk_index_q, rk_index_d;
  logic                     rk_last_q, rk_last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     no_key_err_q, no_key_err_d;

  logic                     start_ok, start_nokey, accept;
  logic [AES_KEXP_BITS-1:0] new_key, sel_key;
  rk_idx_t                  new_n, sel_n, sel_idx;
  logic                     sel_dec, sel_last, sel_mid;
  logic [AES_RK_BITS-1:0]   raw_key, inv_key, key_next;

  // A capture in the same cycle as start counts as a loaded key and is used directly.
  assign start_ok    = (state_q == ST_IDLE) & start_i & (key_loaded_q | key_exp_done_i);
  assign start_nokey = (state_q == ST_IDLE) & start_i & ~key_loaded_q & ~key_exp_done_i;
  assign accept      = (state_q == ST_SERVE) & rk_valid_q & rk_ready_i;

  assign new_key = key_exp_done_i ? key_exp_i : shadow_key_q;
  assign new_n   = key_exp_done_i ? decode_num_rkeys(num_rkeys_i) : shadow_n_q;

  // At session start the next key comes from the key being loaded, afterwards from ACTIVE.
  assign sel_key = start_ok ? new_key   : active_key_q;
  assign sel_n   = start_ok ? new_n     : active_n_q;
  assign sel_dec = start_ok ? decrypt_i : dec_q;

  always_comb begin
    if (start_ok) begin
      sel_idx = sel_dec ? (sel_n - rk_idx_t'(1)) : rk_idx_t'(0);
    end else begin
      sel_idx = sel_dec ? (rk_index_q - rk_idx_t'(1)) : (rk_index_q + rk_idx_t'(1));
    end
  end

  assign sel_last = sel_dec ? (sel_idx == rk_idx_t'(0)) : (sel_idx == sel_n - rk_idx_t'(1));
  assign sel_mid  = sel_dec & (sel_idx != rk_idx_t'(0)) & (sel_idx != sel_n - rk_idx_t'(1));

  always_comb begin
    raw_key = '0;
    for (int k = 0; k < AES_MAX_RKEYS; k++) begin
      if (sel_idx == rk_idx_t'(k)) begin
        raw_key = sel_key[AES_KEXP_BITS-1-AES_RK_BITS*k -: AES_RK_BITS];
      end
    end
  end

  aes_inv_mix_columns u_inv_mix (
    .state_i (raw_key),
    .state_o (inv_key)
  );

  assign key_next = (EQ_INV && sel_mid) ? inv_key : raw_key;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_SERVE;
      ST_SERVE: if (accept && rk_last_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs (next values of the registered stream/status outputs)
  always_comb begin
    rk_valid_d   = rk_valid_q;
    rk_data_d    = rk_data_q;
    rk_index_d   = rk_index_q;
    rk_last_d    = rk_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    no_key_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          rk_valid_d = 1'b1;
          rk_data_d  = key_next;
          rk_index_d = sel_idx;
          rk_last_d  = sel_last;
          busy_d     = 1'b1;
        end else if (start_nokey) begin
          no_key_err_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (accept) begin
          if (rk_last_q) begin
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            rk_data_d  = key_next;
            rk_index_d = sel_idx;
            rk_last_d  = sel_last;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_valid_q   <= 1'b0;
      rk_data_q    <= '0;
      rk_index_q   <= '0;
      rk_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      no_key_err_q <= 1'b0;
    end else begin
      rk_valid_q   <= rk_valid_d;
      rk_data_q    <= rk_data_d;
      rk_index_q   <= rk_index_d;
      rk_last_q    <= rk_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      no_key_err_q <= no_key_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_key_q <= '0;
      shadow_n_q   <= '0;
      key_loaded_q <= 1'b0;
    end else if (key_exp_done_i) begin
      shadow_key_q <= key_exp_i;
      shadow_n_q   <= decode_num_rkeys(num_rkeys_i);
      key_loaded_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_key_q <= '0;
      active_n_q   <= '0;
      dec_q        <= 1'b0;
    end else if (start_ok) begin
      active_key_q <= new_key;
      active_n_q   <= new_n;
      dec_q        <= decrypt_i;
    end
  end

  assign rk_valid_o   = rk_valid_q;
  assign rk_data_o    = rk_data_q;
  assign rk_index_o   = rk_index_q;
  assign rk_last_o    = rk_last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign no_key_err_o = no_key_err_q;

endmodule

// File: tb/tb_aes_round_key_server.sv
// tb/tb_aes_round_key_server.sv - directed self-checking bench for aes_round_key_server
module tb_aes_round_key_server;

  logic          clk = 1'b0;
  logic          rst;
  logic [1919:0] key_exp;
  logic          key_exp_done;
  logic [4:0]    num_rkeys;
  logic          start, decrypt, rk_ready;

  logic          rk_valid_r, rk_last_r, busy_r, done_r, no_key_err_r;
  logic [127:0]  rk_data_r;
  logic [3:0]    rk_index_r;
  logic          rk_valid_e, rk_last_e, busy_e, done_e, no_key_err_e;
  logic [127:0]  rk_data_e;
  logic [3:0]    rk_index_e;

  logic [127:0]  imc_in, imc_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0]  gen_rk [15];
  logic [1919:0] gen_kexp;
  logic [127:0]  exp_rk [15];
  logic [127:0]  rk_a [15];
  logic [127:0]  rk_b [15];
  logic [1919:0] kexp_a, alt_kexp;
  logic [4:0]    alt_num;
  int            nxt;

  always #5 clk = ~clk;

  aes_round_key_server #(.EQ_INV(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .key_exp_i(key_exp), .key_exp_done_i(key_exp_done),
    .num_rkeys_i(num_rkeys), .start_i(start), .decrypt_i(decrypt),
    .rk_valid_o(rk_valid_r), .rk_ready_i(rk_ready), .rk_data_o(rk_data_r),
    .rk_index_o(rk_index_r), .rk_last_o(rk_last_r), .busy_o(busy_r),
    .done_o(done_r), .no_key_err_o(no_key_err_r)
  );

  aes_round_key_server #(.EQ_INV(1'b1)) dut_eq (
    .clk(clk), .rst(rst), .key_exp_i(key_exp), .key_exp_done_i(key_exp_done),
    .num_rkeys_i(num_rkeys), .start_i(start), .decrypt_i(decrypt),
    .rk_valid_o(rk_valid_e), .rk_ready_i(rk_ready), .rk_data_o(rk_data_e),
    .rk_index_o(rk_index_e), .rk_last_o(rk_last_e), .busy_o(busy_e),
    .done_o(done_e), .no_key_err_o(no_key_err_e)
  );

  aes_inv_mix_columns u_imc (.state_i(imc_in), .state_o(imc_out));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] golden_imc(input logic [127:0] s);
    logic [7:0]   base [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] r;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], base[(j - row + 4) % 4]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    gen_kexp = '0;
    for (int r = 0; r < 15; r++) begin
      gen_rk[r] = (r < nk + 7) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      gen_kexp[1919-128*r -: 128] = gen_rk[r];
    end
  endtask

  task automatic capture(input logic [1919:0] kv, input logic [4:0] n);
    key_exp = kv; num_rkeys = n; key_exp_done = 1'b1;
    tick;
    key_exp_done = 1'b0;
  endtask

  task automatic start_session(input logic dec);
    start = 1'b1; decrypt = dec;
    tick;
    start = 1'b0;
  endtask

  // Checks one full session with rk_ready held high, starting at the first beat.
  task automatic serve_check(input string tag, input logic dec, input int n,
                             input logic [127:0] lit_first, input logic [127:0] lit_last,
                             input int start_beat, input int cap_beat);
    int           ei;
    logic [127:0] e_eq;
    for (int b = 0; b < n; b++) begin
      ei   = dec ? n - 1 - b : b;
      e_eq = (dec && ei != 0 && ei != n - 1) ? golden_imc(exp_rk[ei]) : exp_rk[ei];
      chk({tag, "_valid"}, {rk_valid_r, rk_valid_e}, 2'b11);
      chk({tag, "_busy"}, {busy_r, busy_e}, 2'b11);
      chk({tag, "_index"}, {rk_index_r, rk_index_e}, {4'(ei), 4'(ei)});
      chk({tag, "_data_raw"}, rk_data_r, exp_rk[ei]);
      chk({tag, "_data_eqinv"}, rk_data_e, e_eq);
      chk({tag, "_last"}, {rk_last_r, rk_last_e}, (b == n - 1) ? 2'b11 : 2'b00);
      if (b == 0)     chk({tag, "_first_key"}, rk_data_r, lit_first);
      if (b == n - 1) chk({tag, "_last_key"}, rk_data_r, lit_last);
      if (b == start_beat) begin start = 1'b1; decrypt = ~dec; end
      if (b == cap_beat) begin
        key_exp = alt_kexp; num_rkeys = alt_num; key_exp_done = 1'b1;
      end
      tick;
      start = 1'b0; key_exp_done = 1'b0;
    end
    chk({tag, "_done"}, {done_r, done_e}, 2'b11);
    chk({tag, "_end_valid_busy_last"}, {rk_valid_r, rk_valid_e, busy_r, busy_e, rk_last_r, rk_last_e}, 6'b0);
    start = 1'b1; decrypt = 1'b0;
    tick;
    start = 1'b0;
    chk({tag, "_start_in_done_ignored"}, {rk_valid_r, rk_valid_e, busy_r, busy_e, done_r, done_e}, 6'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {rk_valid_r, rk_last_r, busy_r, done_r, no_key_err_r,
                         rk_valid_e, rk_last_e, busy_e, done_e, no_key_err_e}, 10'b0);
    chk({tag, "_data"}, rk_data_r | rk_data_e, 128'h0);
    chk({tag, "_index"}, {rk_index_r, rk_index_e}, 8'h0);
  endtask

  initial begin
    rst = 1'b1; key_exp = '0; key_exp_done = 1'b0; num_rkeys = 5'd0;
    start = 1'b0; decrypt = 1'b0; rk_ready = 1'b1; imc_in = '0;
    alt_kexp = '0; alt_num = 5'd11;
    tick; tick;
    chk_all_zero("reset_held");
    rst = 1'b0;
    tick;
    chk_all_zero("reset_released");

    // start before any key capture
    start_session(1'b0);
    chk("nokey_err_pulse", {no_key_err_r, no_key_err_e}, 2'b11);
    chk("nokey_idle", {busy_r, busy_e, rk_valid_r, rk_valid_e}, 4'b0);
    tick;
    chk("nokey_err_drop", {no_key_err_r, no_key_err_e}, 2'b00);

    // AES-128 encrypt, FIPS-197 C.1 key; a start mid-session is ignored
    expand(256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000, 4);
    rk_a = gen_rk; kexp_a = gen_kexp; exp_rk = gen_rk;
    capture(kexp_a, 5'd11);
    start_session(1'b0);
    serve_check("aes128_enc", 1'b0, 11, 128'h000102030405060708090a0b0c0d0e0f,
                128'h13111d7fe3944a17f307a78b4d2b30c5, 4, -1);

    // AES-256 decrypt, FIPS-197 C.3 key
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    exp_rk = gen_rk;
    capture(gen_kexp, 5'd15);
    start_session(1'b1);
    serve_check("aes256_dec", 1'b1, 15, 128'h24fc79ccbf0979e9371ac23c6d68de36,
                128'h000102030405060708090a0b0c0d0e0f, -1, -1);

    // InvMixColumns unit vectors
    imc_in = {4{32'h01010101}};
    #1 chk("imc_01010101", imc_out, {4{32'h01010101}});
    imc_in = '0;
    #1 chk("imc_zero", imc_out, 128'h0);
    imc_in = {32'h8e4da1bc, 32'h01010101, 32'h00000000, 32'h8e4da1bc};
    #1 chk("imc_mixed", imc_out, {32'hdb135345, 32'h01010101, 32'h00000000, 32'hdb135345});

    // AES-128 decrypt with equivalent inverse keys; illegal num_rkeys 7 serves as 11
    exp_rk = rk_a;
    capture(kexp_a, 5'd7);
    start_session(1'b1);
    serve_check("aes128_dec", 1'b1, 11, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                128'h000102030405060708090a0b0c0d0e0f, -1, -1);

    // backpressure: forced stalls every fourth cycle, random otherwise
    capture(kexp_a, 5'd11);
    start_session(1'b0);
    nxt = 0;
    for (int c = 0; c < 400 && nxt < 11; c++) begin
      rk_ready = (c % 4 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      chk("bp_valid", {rk_valid_r, rk_valid_e}, 2'b11);
      chk("bp_index", {rk_index_r, rk_index_e}, {4'(nxt), 4'(nxt)});
      chk("bp_data", rk_data_r, rk_a[nxt]);
      chk("bp_data_eq", rk_data_e, rk_a[nxt]);
      chk("bp_last", {rk_last_r, rk_last_e}, (nxt == 10) ? 2'b11 : 2'b00);
      if (rk_ready) nxt++;
      tick;
    end
    rk_ready = 1'b1;
    chk("bp_beat_count", 128'(nxt), 128'd11);
    chk("bp_done", {done_r, done_e, rk_valid_r, rk_valid_e}, 4'b1100);
    tick;

    // re-key mid-session: old keys finish, next session uses the new key
    expand(256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000, 4);
    rk_b = gen_rk; alt_kexp = gen_kexp; alt_num = 5'd11;
    exp_rk = rk_a;
    capture(kexp_a, 5'd11);
    start_session(1'b0);
    serve_check("midcap_old", 1'b0, 11, 128'h000102030405060708090a0b0c0d0e0f,
                128'h13111d7fe3944a17f307a78b4d2b30c5, -1, 3);
    exp_rk = rk_b;
    start_session(1'b0);
    serve_check("midcap_new", 1'b0, 11, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, -1, -1);

    // start together with a capture: the captured key is served, not the shadow
    key_exp = kexp_a; num_rkeys = 5'd11; key_exp_done = 1'b1;
    start = 1'b1; decrypt = 1'b0;
    tick;
    start = 1'b0; key_exp_done = 1'b0;
    exp_rk = rk_a;
    serve_check("bypass", 1'b0, 11, 128'h000102030405060708090a0b0c0d0e0f,
                128'h13111d7fe3944a17f307a78b4d2b30c5, -1, -1);

    // reset at beat 5 clears outputs immediately and forgets the key
    start_session(1'b0);
    for (int b = 0; b < 5; b++) tick;
    chk("rst_pre_index", {rk_index_r, rk_index_e}, 8'h55);
    rst = 1'b1;
    #1 chk_all_zero("rst_async");
    tick;
    rst = 1'b0;
    tick;
    start_session(1'b0);
    chk("rst_key_lost_err", {no_key_err_r, no_key_err_e}, 2'b11);
    chk("rst_key_lost_idle", {busy_r, busy_e, rk_valid_r, rk_valid_e}, 4'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
